// File: rtl/multicycle_control_unit.sv
// ============================================================================
//  Module   : multicycle_control_unit
//  Brief    : Moore-style multi-cycle RISC-V control sequencer with memory
//             handshake, illegal-opcode trap and retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter logic MEM_HANDSHAKE = 1'b1,
  parameter int   CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       i_opcode,
  input  logic             i_mem_ready,
  output logic             o_PCWrite,
  output logic             o_PCWriteCond,
  output logic             o_IorD,
  output logic             o_IRWrite,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_MemtoReg,
  output logic             o_RegWrite,
  output logic             o_ALUSrcA,
  output logic             o_PCSource,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_ALUOp,
  output logic [3:0]       o_state,
  output logic             o_instr_done,
  output logic             o_illegal_op,
  output logic [CNT_W-1:0] o_retired
);

  localparam logic [3:0] c_IDLE     = 4'd0;
  localparam logic [3:0] c_FETCH    = 4'd1;
  localparam logic [3:0] c_DECODE   = 4'd2;
  localparam logic [3:0] c_MEM_ADDR = 4'd3;
  localparam logic [3:0] c_MEM_RD   = 4'd4;
  localparam logic [3:0] c_MEM_WR   = 4'd5;
  localparam logic [3:0] c_WB_MEM   = 4'd6;
  localparam logic [3:0] c_EXEC_R   = 4'd7;
  localparam logic [3:0] c_EXEC_I   = 4'd8;
  localparam logic [3:0] c_WB_ALU   = 4'd9;
  localparam logic [3:0] c_BRANCH   = 4'd10;
  localparam logic [3:0] c_TRAP     = 4'd11;

  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  localparam logic [1:0] c_SRCB_RS2 = 2'b00;
  localparam logic [1:0] c_SRCB_4   = 2'b01;
  localparam logic [1:0] c_SRCB_IMM = 2'b10;

  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_BR  = 2'b01;
  localparam logic [1:0] c_ALU_R   = 2'b10;
  localparam logic [1:0] c_ALU_I   = 2'b11;

  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [6:0]       r_opcode;
  logic [CNT_W-1:0] r_retired;
  logic             w_ready;
  logic             w_done;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_ready = MEM_HANDSHAKE ? i_mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_IDLE;
      r_opcode  <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == c_DECODE) begin
        r_opcode <= i_opcode;
      end
      if (w_done) begin
        r_retired <= r_retired + c_ONE;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   w_next = c_FETCH;
      c_FETCH:  w_next = w_ready ? c_DECODE : c_FETCH;
      c_DECODE: begin
        case (i_opcode)
          c_OP_RTYPE:  w_next = c_EXEC_R;
          c_OP_ITYPE:  w_next = c_EXEC_I;
          c_OP_LOAD:   w_next = c_MEM_ADDR;
          c_OP_STORE:  w_next = c_MEM_ADDR;
          c_OP_BRANCH: w_next = c_BRANCH;
          default:     w_next = c_TRAP;
        endcase
      end
      // Only loads and stores reach here; the latched copy decides which.
      c_MEM_ADDR: w_next = (r_opcode == c_OP_LOAD) ? c_MEM_RD : c_MEM_WR;
      c_MEM_RD:   w_next = w_ready ? c_WB_MEM : c_MEM_RD;
      c_MEM_WR:   w_next = w_ready ? c_FETCH : c_MEM_WR;
      c_WB_MEM:   w_next = c_FETCH;
      c_EXEC_R:   w_next = c_WB_ALU;
      c_EXEC_I:   w_next = c_WB_ALU;
      c_WB_ALU:   w_next = c_FETCH;
      c_BRANCH:   w_next = c_FETCH;
      c_TRAP:     w_next = c_TRAP;
      default:    w_next = c_IDLE;
    endcase
  end

  always_comb begin
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_IorD        = 1'b0;
    o_IRWrite     = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_MemtoReg    = 1'b0;
    o_RegWrite    = 1'b0;
    o_ALUSrcA     = 1'b0;
    o_PCSource    = 1'b0;
    o_ALUSrcB     = c_SRCB_RS2;
    o_ALUOp       = c_ALU_ADD;
    w_done        = 1'b0;
    case (r_state)
      c_FETCH: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = c_SRCB_4;
        o_IRWrite = w_ready;
        o_PCWrite = w_ready;
      end
      c_DECODE: begin
        o_ALUSrcB = c_SRCB_IMM;
      end
      c_MEM_ADDR: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = c_SRCB_IMM;
      end
      c_MEM_RD: begin
        o_MemRead = 1'b1;
        o_IorD    = 1'b1;
      end
      c_MEM_WR: begin
        o_MemWrite = 1'b1;
        o_IorD     = 1'b1;
        w_done     = w_ready;
      end
      c_WB_MEM: begin
        o_RegWrite = 1'b1;
        o_MemtoReg = 1'b1;
        w_done     = 1'b1;
      end
      c_EXEC_R: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = c_SRCB_RS2;
        o_ALUOp   = c_ALU_R;
      end
      c_EXEC_I: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = c_SRCB_IMM;
        o_ALUOp   = c_ALU_I;
      end
      c_WB_ALU: begin
        o_RegWrite = 1'b1;
        w_done     = 1'b1;
      end
      c_BRANCH: begin
        o_ALUSrcA     = 1'b1;
        o_ALUSrcB     = c_SRCB_RS2;
        o_ALUOp       = c_ALU_BR;
        o_PCWriteCond = 1'b1;
        o_PCSource    = 1'b1;
        w_done        = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // TRAP is only left through reset, so the state decode is itself sticky.
  assign o_illegal_op = (r_state == c_TRAP);
  assign o_instr_done = w_done;
  assign o_state      = r_state;
  assign o_retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
//  Module   : tb_multicycle_control_unit
//  Brief    : Directed scoreboard bench for multicycle_control_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_X = 7'b1111111;

  logic clk;
  logic rst_n;
  logic [6:0] i_opcode;
  logic mem_ready;
  logic PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, PCSource;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] state;
  logic instr_done, illegal_op;
  logic [31:0] retired;

  logic b_rst_n;
  logic [6:0] b_opcode;
  logic b_ready;
  logic bPCWrite, bPCWriteCond, bIorD, bIRWrite, bMemRead, bMemWrite, bMemtoReg, bRegWrite, bALUSrcA, bPCSource;
  logic [1:0] bALUSrcB, bALUOp;
  logic [3:0] b_state;
  logic b_done, b_illegal;
  logic [3:0] b_retired;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(i_opcode), .i_mem_ready(mem_ready),
    .o_PCWrite(PCWrite), .o_PCWriteCond(PCWriteCond), .o_IorD(IorD), .o_IRWrite(IRWrite),
    .o_MemRead(MemRead), .o_MemWrite(MemWrite), .o_MemtoReg(MemtoReg), .o_RegWrite(RegWrite),
    .o_ALUSrcA(ALUSrcA), .o_PCSource(PCSource), .o_ALUSrcB(ALUSrcB), .o_ALUOp(ALUOp),
    .o_state(state), .o_instr_done(instr_done), .o_illegal_op(illegal_op), .o_retired(retired)
  );

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(b_rst_n), .i_opcode(b_opcode), .i_mem_ready(b_ready),
    .o_PCWrite(bPCWrite), .o_PCWriteCond(bPCWriteCond), .o_IorD(bIorD), .o_IRWrite(bIRWrite),
    .o_MemRead(bMemRead), .o_MemWrite(bMemWrite), .o_MemtoReg(bMemtoReg), .o_RegWrite(bRegWrite),
    .o_ALUSrcA(bALUSrcA), .o_PCSource(bPCSource), .o_ALUSrcB(bALUSrcB), .o_ALUOp(bALUOp),
    .o_state(b_state), .o_instr_done(b_done), .o_illegal_op(b_illegal), .o_retired(b_retired)
  );

  logic [13:0] ctrl, b_ctrl;
  assign ctrl   = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite,
                   ALUSrcA, PCSource, ALUSrcB, ALUOp};
  assign b_ctrl = {bPCWrite, bPCWriteCond, bIorD, bIRWrite, bMemRead, bMemWrite, bMemtoReg, bRegWrite,
                   bALUSrcA, bPCSource, bALUSrcB, bALUOp};

  typedef struct {
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic        done;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;
  int cyc_no  = 0;
  logic [31:0] exp_ret = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control table, bit order {PCWrite,PCWriteCond,IorD,IRWrite,MemRead,MemWrite,MemtoReg,RegWrite,ALUSrcA,PCSource,ALUSrcB,ALUOp}
  function automatic logic [13:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    case (st)
      4'd1:    exp_ctrl = {rdy, 1'b0, 1'b0, rdy, 1'b1, 5'b00000, 2'b01, 2'b00};
      4'd2:    exp_ctrl = {10'b0, 2'b10, 2'b00};
      4'd3:    exp_ctrl = {8'b0, 1'b1, 1'b0, 2'b10, 2'b00};
      4'd4:    exp_ctrl = 14'b00_1_0_1_0_0_0_0_0_00_00;
      4'd5:    exp_ctrl = 14'b00_1_0_0_1_0_0_0_0_00_00;
      4'd6:    exp_ctrl = 14'b00_0_0_0_0_1_1_0_0_00_00;
      4'd7:    exp_ctrl = {8'b0, 1'b1, 1'b0, 2'b00, 2'b10};
      4'd8:    exp_ctrl = {8'b0, 1'b1, 1'b0, 2'b10, 2'b11};
      4'd9:    exp_ctrl = 14'b00_0_0_0_0_0_1_0_0_00_00;
      4'd10:   exp_ctrl = {1'b0, 1'b1, 6'b0, 1'b1, 1'b1, 2'b00, 2'b01};
      default: exp_ctrl = 14'd0;
    endcase
  endfunction

  function automatic logic exp_done(input logic [3:0] st, input logic rdy);
    exp_done = (st == 4'd6) || (st == 4'd9) || (st == 4'd10) || ((st == 4'd5) && rdy);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  // Drive one cycle's inputs, queue the expected response, then compare.
  task automatic check_cycle(input logic [6:0] opc, input logic rdy, input logic [3:0] st);
    exp_t e;
    exp_t g;
    i_opcode  = opc;
    mem_ready = rdy;
    e.st   = st;
    e.ctrl = exp_ctrl(st, rdy);
    e.done = exp_done(st, rdy);
    e.ill  = (st == 4'd11);
    e.ret  = exp_ret;
    sb.push_back(e);
    if (e.done) exp_ret = exp_ret + 32'd1;
    #1;
    g = sb.pop_front();
    chk($sformatf("c%0d_state", cyc_no), 32'(state), 32'(g.st));
    chk($sformatf("c%0d_ctrl", cyc_no), 32'(ctrl), 32'(g.ctrl));
    chk($sformatf("c%0d_done", cyc_no), 32'(instr_done), 32'(g.done));
    chk($sformatf("c%0d_illegal", cyc_no), 32'(illegal_op), 32'(g.ill));
    chk($sformatf("c%0d_retired", cyc_no), retired, g.ret);
    cyc_no++;
  endtask

  task automatic cyc(input logic [6:0] opc, input logic rdy, input logic [3:0] st);
    @(negedge clk);
    check_cycle(opc, rdy, st);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_opcode  = OP_R;
    mem_ready = 1'b1;
    b_rst_n   = 1'b0;
    b_opcode  = OP_B;
    b_ready   = 1'b0;

    @(negedge clk);
    check_cycle(OP_R, 1'b1, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_cycle(OP_R, 1'b1, 4'd0);

    // R-type: 0,1,2,7,9 then FETCH with retired=1
    cyc(OP_R, 1'b1, 4'd1);
    cyc(OP_R, 1'b1, 4'd2);
    cyc(OP_X, 1'b1, 4'd7);
    cyc(OP_X, 1'b1, 4'd9);

    // Load with two wait cycles in MEM_RD; live opcode changed in MEM_ADDR
    cyc(OP_L, 1'b1, 4'd1);
    cyc(OP_L, 1'b1, 4'd2);
    cyc(OP_S, 1'b1, 4'd3);
    cyc(OP_S, 1'b0, 4'd4);
    cyc(OP_S, 1'b0, 4'd4);
    cyc(OP_S, 1'b1, 4'd4);
    cyc(OP_S, 1'b1, 4'd6);

    // Store with a FETCH wait and a MEM_WR wait
    cyc(OP_X, 1'b0, 4'd1);
    cyc(OP_X, 1'b1, 4'd1);
    cyc(OP_S, 1'b1, 4'd2);
    cyc(OP_L, 1'b1, 4'd3);
    cyc(OP_L, 1'b0, 4'd5);
    cyc(OP_L, 1'b1, 4'd5);

    // ALU-immediate
    cyc(OP_I, 1'b1, 4'd1);
    cyc(OP_I, 1'b1, 4'd2);
    cyc(OP_L, 1'b1, 4'd8);
    cyc(OP_L, 1'b1, 4'd9);

    // Branch
    cyc(OP_B, 1'b1, 4'd1);
    cyc(OP_B, 1'b1, 4'd2);
    cyc(OP_R, 1'b1, 4'd10);

    // Illegal opcode: trap held for 10 cycles regardless of inputs
    cyc(OP_X, 1'b1, 4'd1);
    cyc(OP_X, 1'b1, 4'd2);
    for (int i = 0; i < 10; i++) begin
      cyc((i % 2 == 0) ? OP_R : OP_L, 1'(i % 2), 4'd11);
    end

    // Asynchronous reset pulse clears the trap immediately
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("trap_rst_state", 32'(state), 32'd0);
    chk("trap_rst_illegal", 32'(illegal_op), 32'd0);
    chk("trap_rst_retired", retired, 32'd0);
    exp_ret = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cycle(OP_S, 1'b1, 4'd0);

    // Store abandoned by reset while waiting in MEM_WR
    cyc(OP_S, 1'b1, 4'd1);
    cyc(OP_S, 1'b1, 4'd2);
    cyc(OP_R, 1'b1, 4'd3);
    cyc(OP_R, 1'b0, 4'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_retired", retired, 32'd0);

    // Narrow counter, handshake disabled, mem_ready held low: 16 branches wrap
    @(negedge clk);
    b_rst_n = 1'b1;
    #1;
    chk("w_idle_state", 32'(b_state), 32'd0);
    chk("w_idle_ctrl", 32'(b_ctrl), 32'd0);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("w%0d_fetch_state", i), 32'(b_state), 32'd1);
      chk($sformatf("w%0d_fetch_ctrl", i), 32'(b_ctrl), 32'(exp_ctrl(4'd1, 1'b1)));
      chk($sformatf("w%0d_retired", i), 32'(b_retired), 32'(i % 16));
      if (i < 16) begin
        @(negedge clk);
        #1;
        chk($sformatf("w%0d_decode_state", i), 32'(b_state), 32'd2);
        @(negedge clk);
        #1;
        chk($sformatf("w%0d_branch_state", i), 32'(b_state), 32'd10);
        chk($sformatf("w%0d_branch_ctrl", i), 32'(b_ctrl), 32'(exp_ctrl(4'd10, 1'b1)));
        chk($sformatf("w%0d_branch_done", i), 32'({b_done, b_illegal}), 32'd2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the RISC-V core: sequences each instruction through fetch, decode, execute, memory and write-back states and drives all datapath enables per state. It generalises the single-cycle opcode decoder into a Moore-style sequencer. It adds a memory-ready handshake, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register's opcode field and the shared-memory multi-cycle datapath.

## Interface
- MEM_HANDSHAKE, 1, 1: FETCH/MEM_RD/MEM_WR wait for mem_ready; 0: mem_ready ignored, treated as 1
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instruction[6:0] from IR, sampled in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, PCSource  out  1 each  datapath controls
- ALUSrcB  out  2  00 rs2, 01 constant 4, 10 immediate
- ALUOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- state  out  4  current state encoding, for debug
- instr_done  out  1  one-cycle pulse in the final cycle of each legal instruction
- illegal_op  out  1  sticky trap flag
- retired  out  CNT_W  count of completed instructions

## Operation
- States and encodings:
  - IDLE=0
  - FETCH=1
  - DECODE=2
  - MEM_ADDR=3
  - MEM_RD=4
  - MEM_WR=5
  - WB_MEM=6
  - EXEC_R=7
  - EXEC_I=8
  - WB_ALU=9
  - BRANCH=10
  - TRAP=11
- Output defaults are 0 in every state. Only the listed signals assert.
- IDLE: always goes to FETCH next cycle.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=00 (precomputes the branch target).
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 -> MEM_ADDR
    - 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - any other -> TRAP
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Goes to MEM_RD for a load, MEM_WR for a store.
  - The opcode is latched in DECODE into an internal register. MEM_ADDR uses that register, not the live input.
- MEM_RD: MemRead=1, IorD=1. Waits on mem_ready, then goes to WB_MEM.
- MEM_WR: MemWrite=1, IorD=1, instr_done=mem_ready. Waits on mem_ready, then goes to FETCH.
- WB_MEM: RegWrite=1, MemtoReg=1, instr_done=1. Goes to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Goes to WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, instr_done=1. Goes to FETCH.
- TRAP:
  - illegal_op=1; every other control is 0.
  - Remains in TRAP until rst_n is asserted.
  - instr_done is never pulsed and retired does not increment.
- MemRead asserts only in FETCH and MEM_RD. ALU-immediate instructions never read memory.
- retired:
  - Increments by 1 on each clock edge where instr_done=1.
  - Wraps from 2^CNT_W-1 to 0 with no flag.

## Timing
- Reset:
  - state=IDLE, retired=0, illegal_op=0, latched opcode=0.
  - All control outputs are 0 while rst_n=0 and in the first cycle after release.
- Assertion of rst_n mid-instruction forces IDLE immediately (asynchronous). A store in progress is abandoned: MemWrite drops the same instant.
- Cycles per instruction with mem_ready held at 1:
  - branch: 3
  - R-type, ALU-immediate, store: 4
  - load: 5
- Each cycle mem_ready is low in FETCH/MEM_RD/MEM_WR adds one cycle. All outputs hold for the wait cycles, except the mem_ready-qualified ones.
- The opcode input only needs to be valid in DECODE.
- instr_done and the retired increment coincide with the final state's last cycle. retired shows the new value one cycle later.
- With MEM_HANDSHAKE=0, cycle counts are independent of mem_ready.

## Test plan
- Reset release with opcode=0110011 and mem_ready=1:
  - state sequence 0,1,2,7,9,1.
  - RegWrite=1 only in state 9.
  - retired=1 one cycle after WB_ALU.
- Load 0000011 with mem_ready low for 2 cycles in MEM_RD:
  - sequence 1,2,3,4,4,4,6,1.
  - MemtoReg=1 and RegWrite=1 in state 6.
  - 7 cycles total.
- Store 0100011:
  - MemWrite=1, IorD=1 in MEM_WR.
  - instr_done pulses once.
  - RegWrite stays 0 throughout.
- ALU-immediate 0010011:
  - MemRead=0 in every non-FETCH cycle.
  - ALUOp=11 in EXEC_I.
- Opcode 1111111 in DECODE:
  - TRAP entered, illegal_op=1 held for 10 cycles.
  - retired unchanged.
  - rst_n pulse clears illegal_op and returns to IDLE.
- CNT_W=4, 16 back-to-back branches: retired wraps 15->0. Separately, rst_n asserted in MEM_WR drops MemWrite asynchronously.
